// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command field widths, bit positions and the field-to-command packer
package cmd_pkg;
  localparam int OPC_W   = 6;
  localparam int ADDR_W  = 16;
  localparam int DIN_W   = 32;
  localparam int CMD_W   = 56;
  localparam int OPC_LSB = 50;
  localparam int A1_LSB  = 34;
  localparam int A2_LSB  = 16;
  localparam int A3_LSB  = 0;
  localparam int DIN_LSB = 0;

  // Bits [33:32] stay zero; the low word is either DIN (mem) or addr2/addr3 (ALU).
  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic              is_mem,
    input logic [OPC_W-1:0]  opc,
    input logic [ADDR_W-1:0] a1,
    input logic [ADDR_W-1:0] a2,
    input logic [ADDR_W-1:0] a3,
    input logic [DIN_W-1:0]  din
  );
    logic [CMD_W-1:0] c;
    c = '0;
    c[OPC_LSB +: OPC_W] = opc;
    c[A1_LSB +: ADDR_W] = a1;
    if (is_mem) c[DIN_LSB +: DIN_W] = din;
    else begin
      c[A2_LSB +: ADDR_W] = a2;
      c[A3_LSB +: ADDR_W] = a3;
    end
    return c;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH x W synchronous valid/ready FIFO with registered storage cleared on reset
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready/in_data   : push side, in_ready = not full
//   out_valid/out_ready/out_data: pop side, out_data = head entry
//   count                       : occupancy 0..DEPTH
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 56
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign in_ready  = r_count < (AW+1)'(DEPTH);
  assign out_valid = r_count != '0;
  assign out_data  = r_mem[r_rd];
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '{default: '0};
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= in_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/cmd_packer.sv
// cmd_packer: packs opcode/address/data fields into 56-bit commands and queues them to the scheduler
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready + in_* fields : one field set per handshake
//   out_valid/out_ready/out_cmd     : packed command stream (FIFO head)
//   fifo_count, issued_cnt          : debug occupancy and wrapping issue count
module cmd_packer
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_mem,
  input  logic [OPC_W-1:0]       in_opcode,
  input  logic [ADDR_W-1:0]      in_addr1,
  input  logic [ADDR_W-1:0]      in_addr2,
  input  logic [ADDR_W-1:0]      in_addr3,
  input  logic [DIN_W-1:0]       in_din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CMD_W-1:0]       out_cmd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       issued_cnt
);
  logic [CMD_W-1:0] w_cmd;
  logic [CNT_W-1:0] r_issued;

  assign w_cmd      = pack_cmd(in_is_mem, in_opcode, in_addr1, in_addr2, in_addr3, in_din);
  assign issued_cnt = r_issued;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_cmd),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_issued <= '0;
    else if (out_valid && out_ready) r_issued <= r_issued + CNT_W'(1);
  end
endmodule

// File: tb/tb_cmd_packer.sv
// tb_cmd_packer: randomized self-checking bench for cmd_packer against a queue-based reference model
module tb_cmd_packer;
  localparam int DEPTH = 4;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_mem;
  logic [5:0]  in_opcode;
  logic [15:0] in_addr1, in_addr2, in_addr3;
  logic [31:0] in_din;
  logic        out_valid, out_ready;
  logic [55:0] out_cmd;
  logic [2:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic        in_ready2, out_valid2;
  logic [55:0] out_cmd2;
  logic [1:0]  fifo_count2;
  logic [3:0]  issued_cnt2;

  logic [55:0] mq[$];
  logic [15:0] m_issued;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_packer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
    .in_opcode(in_opcode), .in_addr1(in_addr1), .in_addr2(in_addr2), .in_addr3(in_addr3),
    .in_din(in_din), .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .fifo_count(fifo_count), .issued_cnt(issued_cnt)
  );

  cmd_packer #(.DEPTH(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_is_mem(in_is_mem),
    .in_opcode(in_opcode), .in_addr1(in_addr1), .in_addr2(in_addr2), .in_addr3(in_addr3),
    .in_din(in_din), .out_valid(out_valid2), .out_ready(out_ready), .out_cmd(out_cmd2),
    .fifo_count(fifo_count2), .issued_cnt(issued_cnt2)
  );

  function automatic logic [55:0] model_cmd(input logic m, input logic [5:0] op, input logic [15:0] a1,
                                            input logic [15:0] a2, input logic [15:0] a3, input logic [31:0] d);
    longint unsigned v;
    v = longint'(op) * (64'd1 << 50) + longint'(a1) * (64'd1 << 34);
    v = v + (m ? longint'(d) : longint'(a2) * 65536 + longint'(a3));
    return v[55:0];
  endfunction

  task automatic rand_fields();
    in_is_mem = 1'($urandom);
    in_opcode = 6'($urandom);
    in_addr1  = 16'($urandom);
    in_addr2  = 16'($urandom);
    in_addr3  = 16'($urandom);
    in_din    = $urandom;
  endtask

  task automatic step();
    bit acc, pop;
    logic [55:0] c;
    acc = in_valid && (mq.size() < DEPTH);
    pop = out_ready && (mq.size() != 0);
    c = model_cmd(in_is_mem, in_opcode, in_addr1, in_addr2, in_addr3, in_din);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_issued = m_issued + 16'd1;
    end
    if (acc) mq.push_back(c);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #1;
    rst_n = 1;
    mq.delete();
    m_issued = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; rand_fields();
    mq.delete(); m_issued = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL reset_issued got %0d exp 0", issued_cnt); end
    checks++; if (out_cmd !== 56'd0) begin errors++; $display("FAIL reset_out_cmd got %h exp 0", out_cmd); end
    @(posedge clk); #1; rst_n = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_alu_pack();
    in_is_mem = 0; in_opcode = 6'h2A; in_addr1 = 16'h1234; in_addr2 = 16'hABCD; in_addr3 = 16'h5678;
    in_din = 32'hFFFFFFFF; in_valid = 1; out_ready = 1;
    step(); in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", out_valid); end
    checks++; if (out_cmd !== 56'hA848D0ABCD5678) begin errors++; $display("FAIL alu_cmd got %h exp a848d0abcd5678", out_cmd); end
    checks++; if (out_cmd !== mq[0]) begin errors++; $display("FAIL alu_model got %h exp %h", out_cmd, mq[0]); end
    step();
    checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL alu_issued got %0d exp 1", issued_cnt); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL alu_count got %0d exp 0", fifo_count); end
  endtask

  task automatic test_mem_pack();
    in_is_mem = 1; in_opcode = 6'h01; in_addr1 = 16'hFFFF; in_addr2 = 16'($urandom); in_addr3 = 16'($urandom);
    in_din = 32'hDEADBEEF; in_valid = 1; out_ready = 1;
    step(); in_valid = 0;
    checks++; if (out_cmd !== 56'h07FFFCDEADBEEF) begin errors++; $display("FAIL mem_cmd got %h exp 07fffcdeadbeef", out_cmd); end
    step();
  endtask

  task automatic test_fill_backpressure();
    logic [55:0] first;
    logic [15:0] base;
    base = m_issued; out_ready = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      checks++;
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, in_ready, i < 4); end
      step();
    end
    in_valid = 0; first = mq[0];
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", in_ready); end
    checks++; if (out_cmd !== first) begin errors++; $display("FAIL fill_head got %h exp %h", out_cmd, first); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_cmd !== mq[0]) begin errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, out_cmd, mq[0]); end
      step();
    end
    checks++; if (issued_cnt - base !== 16'd4) begin errors++; $display("FAIL drain_issued got %0d exp 4", issued_cnt - base); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full_simultaneous();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin rand_fields(); step(); end
    out_ready = 1; rand_fields();
    step();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_sim_count got %0d exp 3", fifo_count); end
    rand_fields();
    step();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_sim_next_count got %0d exp 3", fifo_count); end
    in_valid = 0;
    while (mq.size() != 0) begin
      checks++; if (out_cmd !== mq[0]) begin errors++; $display("FAIL full_sim_order got %h exp %h", out_cmd, mq[0]); end
      step();
    end
  endtask

  task automatic test_streaming();
    logic [15:0] base;
    base = m_issued; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      rand_fields(); in_opcode = 6'(k);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_cmd !== mq[0] || out_cmd[55:50] !== 6'(k))
        begin errors++; $display("FAIL stream[%0d] got %h exp %h", k, out_cmd, mq[0]); end
      checks++;
      if (issued_cnt - base !== 16'(k)) begin errors++; $display("FAIL stream_issued[%0d] got %0d exp %0d", k, issued_cnt - base, k); end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rand_fields(); in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (fifo_count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() != 0) || issued_cnt !== m_issued)
        begin errors++; $display("FAIL rand_state[%0d] got cnt=%0d rdy=%b vld=%b iss=%0d exp cnt=%0d iss=%0d", n, fifo_count, in_ready, out_valid, issued_cnt, mq.size(), m_issued); end
      if (mq.size() != 0) begin
        checks++; if (out_cmd !== mq[0]) begin errors++; $display("FAIL rand_cmd[%0d] got %h exp %h", n, out_cmd, mq[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; out_ready = 0;
    while (mq.size() < 3) begin rand_fields(); step(); end
    in_valid = 0;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", fifo_count); end
    checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_issued got %0d exp 0", issued_cnt); end
    #1; rst_n = 1; mq.delete(); m_issued = 0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", in_ready); end
    checks++; if (out_cmd !== 56'd0) begin errors++; $display("FAIL mid_reset_cmd got %h exp 0", out_cmd); end
  endtask

  task automatic test_cnt_wrap();
    bit wrapped;
    wrapped = 0;
    pulse_reset();
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      rand_fields();
      step();
      if (m_issued == 16'd16) wrapped = 1;
      checks++;
      if (issued_cnt2 !== m_issued[3:0]) begin errors++; $display("FAIL wrap_issued[%0d] got %0d exp %0d", k, issued_cnt2, m_issued[3:0]); end
    end
    checks++; if (!wrapped || issued_cnt2 !== 4'd3) begin errors++; $display("FAIL wrap_final got %0d exp 3", issued_cnt2); end
    in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_pack();
    test_mem_pack();
    test_fill_backpressure();
    test_full_simultaneous();
    test_streaming();
    test_random();
    test_reset_mid();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
